// File: rtl/i2c_slave_tx_if.sv
// Bus-side and producer-side signals of the I2C slave transmitter.
// The slave modport is the DUT view; the master modport drives the DUT.
interface i2c_slave_tx_if;
  logic       scl;
  logic       sda_in;
  logic       write_enable;
  logic [7:0] write_data;
  logic       sda_out;
  logic       fifo_empty;
  logic       fifo_full;

  modport slave (
    input  scl, sda_in, write_enable, write_data,
    output sda_out, fifo_empty, fifo_full
  );

  modport master (
    output scl, sda_in, write_enable, write_data,
    input  sda_out, fifo_empty, fifo_full
  );
endinterface

// File: rtl/i2c_slave_tx.sv
// Read-only I2C slave transmitter: local producer fills a byte FIFO, an
// external master addresses the slave for read and clocks bytes out MSB-first.
module i2c_slave_tx #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1111000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           n_rst,
  i2c_slave_tx_if.slave  bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    LOAD,
    SEND,
    MACK
  } state_e;

  // Two synchronizer flops plus one history flop per bus line.
  logic [2:0] scl_pipe_q;
  logic [2:0] sda_pipe_q;
  logic       scl_s, scl_prev, sda_s, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      scl_pipe_q <= '1;
      sda_pipe_q <= '1;
    end else begin
      scl_pipe_q <= {scl_pipe_q[1:0], bus.scl};
      sda_pipe_q <= {sda_pipe_q[1:0], bus.sda_in};
    end
  end

  always_comb begin
    scl_s     = scl_pipe_q[1];
    scl_prev  = scl_pipe_q[2];
    sda_s     = sda_pipe_q[1];
    sda_prev  = sda_pipe_q[2];
    scl_rise  = scl_s && !scl_prev;
    scl_fall  = !scl_s && scl_prev;
    start_det = scl_s && scl_prev && sda_prev && !sda_s;
    stop_det  = scl_s && scl_prev && !sda_prev && sda_s;
  end

  // Transmit FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q;
  logic          push, pop, load_fire;
  logic [7:0]    head, load_byte;

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] tx_q;
  logic       sda_out_q;
  logic       ack_q;

  // START/STOP take priority over LOAD, so a pop only happens if LOAD really runs.
  assign load_fire = (state_q == LOAD) && !start_det && !stop_det;
  assign pop       = load_fire && !empty_q;
  assign head      = mem_q[rd_ptr_q];
  assign load_byte = empty_q ? 8'hFF : head;

  always_comb begin
    push     = bus.write_enable && (!full_q || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst && push) mem_q[wr_ptr_q] <= bus.write_data;
  end

  // Protocol FSM; sda_out only moves after a detected SCL fall or START/STOP.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      sda_out_q <= 1'b1;
      ack_q     <= 1'b0;
    end else if (start_det) begin
      state_q   <= ADDR;
      bit_cnt_q <= '0;
      sda_out_q <= 1'b1;
    end else if (stop_det) begin
      state_q   <= IDLE;
      sda_out_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sda_out_q <= 1'b1;
        end
        ADDR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_q   <= {shift_q[6:0], sda_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR && shift_q[0]) begin
              sda_out_q <= 1'b0;
              state_q   <= ADDR_ACK;
            end else begin
              sda_out_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) state_q <= LOAD;
        end
        LOAD: begin
          tx_q      <= load_byte;
          sda_out_q <= load_byte[7];
          bit_cnt_q <= '0;
          state_q   <= SEND;
        end
        SEND: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_out_q <= 1'b1;
              ack_q     <= 1'b0;
              state_q   <= MACK;
            end else begin
              tx_q      <= {tx_q[6:0], 1'b0};
              sda_out_q <= tx_q[6];
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda_s) state_q <= IDLE;
            else       ack_q   <= 1'b1;
          end else if (scl_fall && ack_q) begin
            state_q <= LOAD;
          end
        end
        default: begin
          state_q   <= IDLE;
          sda_out_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.sda_out    = sda_out_q;
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_full  = full_q;

endmodule

// File: tb/tb_i2c_slave_tx.sv
// Directed bench for i2c_slave_tx: a bit-banged I2C master on a wired-AND SDA
// and a byte scoreboard filled on push, drained as bytes arrive on the bus.
module tb_i2c_slave_tx;

  localparam int unsigned DEPTH = 8;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  i2c_slave_tx_if bus_if ();

  assign bus_if.scl    = scl_m;
  assign bus_if.sda_in = sda_m & bus_if.sda_out;

  i2c_slave_tx #(
    .SLAVE_ADDR (7'b1111000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    bus_if.write_enable = 1'b1;
    bus_if.write_data   = b;
    @(negedge clk);
    bus_if.write_enable = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
  endtask

  // Bus tasks enter and leave with SCL low (except bus_stop, which leaves it high).
  task automatic bus_start();
    scl_m = 1'b0;
    #50  sda_m = 1'b1;
    #150 scl_m = 1'b1;
    #100 sda_m = 1'b0;
    #100 scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    #50  sda_m = 1'b0;
    #150 scl_m = 1'b1;
    #100 sda_m = 1'b1;
    #100;
  endtask

  task automatic send_bit(input logic b, output logic seen);
    #50  sda_m = b;
    #150 scl_m = 1'b1;
    #50  seen = bus_if.sda_out;
    #50  scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    #50  sda_m = 1'b1;
    #150 scl_m = 1'b1;
    #50  b = bus_if.sda_out;
    #50  scl_m = 1'b0;
  endtask

  task automatic send_addr_bits(input logic [7:0] a, output logic rel);
    logic s;
    rel = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(a[i], s);
      rel &= s;
    end
  endtask

  task automatic addr_phase(input logic [7:0] a, output logic ack_bit, output logic rel);
    send_addr_bits(a, rel);
    read_bit(ack_bit);
  endtask

  task automatic read_and_check(input string tag, input logic nack);
    logic [7:0] d;
    logic [7:0] e;
    logic s;
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
    chk8(tag, d, e);
    send_bit(nack, s);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack_bit, rel, b;
    bus_if.write_enable = 1'b0;
    bus_if.write_data   = 8'h00;
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    chk1("rst_sda", bus_if.sda_out, 1'b1);
    chk1("rst_empty", bus_if.fifo_empty, 1'b1);
    chk1("rst_full", bus_if.fifo_full, 1'b0);

    push(8'h0F);
    chk1("push_not_empty", bus_if.fifo_empty, 1'b0);

    // Addressed read of a single byte
    bus_start();
    addr_phase(8'hF1, ack_bit, rel);
    chk1("addr_ack", ack_bit, 1'b0);
    chk1("addr_released", rel, 1'b1);
    read_and_check("byte0F", 1'b1);
    chk1("pop_empty", bus_if.fifo_empty, 1'b1);
    bus_stop();

    // Multi-byte with master ACK then NACK; third byte must stay queued
    push(8'h0F);
    push(8'h4F);
    push(8'h00);
    bus_start();
    addr_phase(8'hF1, ack_bit, rel);
    chk1("multi_ack", ack_bit, 1'b0);
    read_and_check("multi_b0", 1'b0);
    read_and_check("multi_b1", 1'b1);
    read_bit(b);
    chk1("post_nack_idle", b, 1'b1);
    chk1("post_nack_notempty", bus_if.fifo_empty, 1'b0);
    bus_stop();
    chk1("post_stop_sda", bus_if.sda_out, 1'b1);

    // Wrong address, then right address with write direction
    bus_start();
    addr_phase(8'hAB, ack_bit, rel);
    chk1("wrong_addr_nack", rel & ack_bit, 1'b1);
    chk1("wrong_addr_fifo", bus_if.fifo_empty, 1'b0);
    bus_stop();
    bus_start();
    addr_phase(8'hF0, ack_bit, rel);
    chk1("write_req_nack", rel & ack_bit, 1'b1);
    chk1("write_req_fifo", bus_if.fifo_empty, 1'b0);
    bus_stop();
    bus_start();
    addr_phase(8'hF1, ack_bit, rel);
    chk1("leftover_ack", ack_bit, 1'b0);
    read_and_check("leftover_00", 1'b1);
    chk1("leftover_empty", bus_if.fifo_empty, 1'b1);
    bus_stop();

    // Read with empty FIFO yields 0xFF
    bus_start();
    addr_phase(8'hF1, ack_bit, rel);
    read_and_check("empty_FF", 1'b1);
    chk1("empty_stays", bus_if.fifo_empty, 1'b1);
    bus_stop();

    // Fill to full, overflow push, then push+pop while full during LOAD
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i * 3));
    chk1("full_set", bus_if.fifo_full, 1'b1);
    chk1("full_not_empty", bus_if.fifo_empty, 1'b0);
    push(8'h99);
    chk1("overflow_full", bus_if.fifo_full, 1'b1);
    bus_start();
    send_addr_bits(8'hF1, rel);
    bus_if.write_data   = 8'hEE;
    bus_if.write_enable = 1'b1;
    read_bit(ack_bit);
    #100;
    bus_if.write_enable = 1'b0;
    exp_q.push_back(8'hEE);
    chk1("full_ack", ack_bit, 1'b0);
    chk1("pushpop_full", bus_if.fifo_full, 1'b1);
    for (int i = 0; i <= DEPTH; i++) read_and_check("full_order", (i == DEPTH) ? 1'b1 : 1'b0);
    chk1("drained_empty", bus_if.fifo_empty, 1'b1);
    bus_stop();

    // Reset while sending 0xA5 (bit 6 is low), then a normal transfer
    push(8'hA5);
    push(8'h3C);
    bus_start();
    addr_phase(8'hF1, ack_bit, rel);
    chk1("midrst_ack", ack_bit, 1'b0);
    read_bit(b);
    chk1("midrst_bit7", b, 1'b1);
    #100;
    chk1("midrst_drive_low", bus_if.sda_out, 1'b0);
    do_reset();
    chk1("midrst_sda", bus_if.sda_out, 1'b1);
    chk1("midrst_empty", bus_if.fifo_empty, 1'b1);
    chk1("midrst_full", bus_if.fifo_full, 1'b0);
    push(8'h3C);
    bus_start();
    addr_phase(8'hF1, ack_bit, rel);
    chk1("after_rst_ack", ack_bit, 1'b0);
    read_and_check("after_rst_3C", 1'b1);
    bus_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_tx.md
Name: i2c_slave_tx

Overview:
- Read-only I2C slave transmitter with an internal byte FIFO.
- The local side pushes bytes through write_enable/write_data.
- An external I2C master addresses the slave with R/W=1 and clocks the queued bytes out MSB-first on an open-drain SDA.
- Sits between a local data producer and the wired-AND I2C bus model, which resolves SCL/SDA from all agents.

Parameters:
- SLAVE_ADDR, 7'b1111000, 7-bit I2C address the slave responds to.
- FIFO_DEPTH, 8, TX FIFO depth in bytes (power of two).

Ports:
- clk  input  1  system clock, at least 10x the SCL rate (100 MHz nominal).
- n_rst  input  1  reset, synchronous, active-high (asserted when 1) despite the name.
- scl  input  1  resolved SCL from bus, asynchronous.
- sda_in  input  1  resolved SDA from bus, asynchronous.
- write_enable  input  1  push write_data into FIFO this cycle.
- write_data  input  8  byte to queue.
- sda_out  output  1  open-drain SDA drive; 0 pulls low, 1 releases.
- fifo_empty  output  1  FIFO holds 0 bytes.
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.

Behaviour:
- Reset (n_rst=1 at clk edge) forces:
  - sda_out=1, FIFO cleared, fifo_empty=1, fifo_full=0.
  - FSM to IDLE, shift registers 0, synchronizers to 1.
- Input conditioning: scl and sda_in each pass through a 2-flop synchronizer. A third flop provides edge detection.
  - rise = SCL 0->1, fall = SCL 1->0, on synchronized values.
  - START = SDA 1->0 while SCL=1. STOP = SDA 0->1 while SCL=1.
- FIFO push: write_enable=1 and not full stores write_data. Push when full is dropped. Push and pop in the same cycle are both performed; the count is unchanged, including at full.
- fifo_empty and fifo_full are registered and reflect the count after the current cycle's push/pop.
- FSM states: IDLE, ADDR, ADDR_ACK, LOAD, SEND, MACK.
  - START from any state -> ADDR, bit count = 0, sda_out=1.
  - STOP from any state -> IDLE, sda_out=1.
  - IDLE: sda_out=1, ignore SCL.
  - ADDR: on each rise shift sda into an 8-bit register (7 address bits, then R/W). After the 8th rise, on the next fall:
    - address==SLAVE_ADDR and R/W=1 -> drive sda_out=0, go to ADDR_ACK.
    - otherwise -> IDLE with sda_out=1 (NACK); remain there until START.
  - ADDR_ACK: hold sda_out=0 through the 9th SCL high. On the following fall -> LOAD.
  - LOAD (1 cycle): pop FIFO head into the TX shift register; if empty, load 8'hFF without popping. Drive MSB onto sda_out. Bit count = 0. -> SEND.
  - SEND: on each fall after the first bit, shift and drive the next bit (MSB first). After the 8th bit's fall, release sda_out=1 -> MACK.
  - MACK: sample sda on rise.
    - 0 (master ACK) -> on next fall go to LOAD.
    - 1 (NACK) -> IDLE.
- sda_out changes only in the cycle after a detected fall, or after START/STOP. It never changes while synchronized SCL=1, except on reset.
- Bus values are not checked against sda_out (no arbitration).
- Reset mid-transfer: immediate return to reset state. The byte in the shift register is lost; FIFO contents are lost.

Test Plan:
- Reset: assert n_rst for 1 clk -> sda_out=1, fifo_empty=1, fifo_full=0. Write 0x0F with write_enable for 1 clk -> fifo_empty=0 two clocks later.
- Addressed read: START, then master sends bits 1,1,1,1,0,0,0 plus R/W=1 (SCL 200 ns low / 100 ns high) -> sda_out=0 during the 9th SCL high. Then bits 0,0,0,0,1,1,1,1 (0x0F) appear on sda_out across the next 8 SCL highs. fifo_empty=1 after the pop.
- Multi-byte: queue 0x0F, 0x4F; master ACKs the first byte -> 0x4F follows. Master NACKs -> sda_out=1 and FSM IDLE; STOP keeps it idle.
- Wrong address / write request: address 0x55, or 0x78 with R/W=0 -> no ACK (sda_out stays 1 for all 9 clocks). FIFO untouched.
- FIFO limits:
  - 8 pushes -> fifo_full=1; a 9th push is ignored and the read-back order is unchanged.
  - Read with empty FIFO -> 0xFF sent, fifo_empty stays 1.
  - Push+pop when full -> fifo_full stays 1.
- Reset mid-byte during SEND -> sda_out=1 next cycle, FIFO empty. The next START+address sequence operates normally.
